// File: rtl/pong_text_pkg.sv
// Shared glyph geometry, character codes and colours for the text banner
// and the character/font ROMs that sit beside it.
package pong_text_pkg;

    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 16;
    localparam int BANNER_COLS = 16;

    localparam logic [6:0] CHAR_BLANK = 7'h20;

    // Character-ROM cell that is always blank; driven whenever the pixel is off-banner.
    localparam logic [7:0] BLANK_CELL_XY = 8'h04;

    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_BLUE  = 12'h00F;

    typedef struct packed {
        logic in_box;
        logic video_on;
        logic hsync;
        logic vsync;
    } pix_ctl_t;

endpackage

// File: rtl/text_blink_ctrl.sv
// Per-frame blink generator: counts frame ticks and toggles blink_phase_o
// every BLINK_FRAMES frames; blinking off keeps the text visible.
module text_blink_ctrl #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic frame_tick_i,
    input  logic blink_en_i,
    output logic blink_phase_o
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             phase_d, phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!blink_en_i || (BLINK_FRAMES == 0)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (frame_tick_i) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase_o = phase_q;

endmodule

// File: rtl/text_banner_pixel_gen.sv
// Three-stage pixel pipeline: banner hit test, char/font ROM addressing and
// font-bit extraction, with sync and video_on delayed to stay aligned.
module text_banner_pixel_gen
    import pong_text_pkg::*;
#(
    parameter logic [9:0]  ORIGIN_X     = 10'd256,
    parameter logic [9:0]  ORIGIN_Y     = 10'd16,
    parameter int          ROWS         = 1,
    parameter logic [11:0] TEXT_RGB     = COLOR_BLUE,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        frame_tick,
    input  logic        blink_en,
    output logic [7:0]  char_xy,
    input  logic [6:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_word,
    output logic        text_on,
    output logic [11:0] text_rgb,
    output logic        video_on_o,
    output logic        hsync_o,
    output logic        vsync_o
);

    // End bounds are 11 bits so an origin near 1023 cannot wrap the compare.
    localparam logic [10:0] X_END = 11'(ORIGIN_X) + 11'(BANNER_COLS * GLYPH_W);
    localparam logic [10:0] Y_END = 11'(ORIGIN_Y) + 11'(GLYPH_H * ROWS);

    pix_ctl_t    ctl_s1_d, ctl_s1_q, ctl_s2_q;
    logic [6:0]  dx_s1_d, dx_s1_q;
    logic [7:0]  dy_s1_d, dy_s1_q;
    logic [2:0]  bit_col_s2_q;
    logic        text_on_d, text_on_q;
    logic [11:0] text_rgb_q;
    logic        video_on_q, hsync_q, vsync_q;
    logic        blink_phase;
    logic        visible;

    text_blink_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk_i         (clk),
        .reset_i       (reset),
        .frame_tick_i  (frame_tick),
        .blink_en_i    (blink_en),
        .blink_phase_o (blink_phase)
    );

    always_comb begin
        dx_s1_d           = 7'(pixel_x - ORIGIN_X);
        dy_s1_d           = 8'(pixel_y - ORIGIN_Y);
        ctl_s1_d.in_box   = (pixel_x >= ORIGIN_X) && ({1'b0, pixel_x} < X_END) &&
                            (pixel_y >= ORIGIN_Y) && ({1'b0, pixel_y} < Y_END) &&
                            video_on;
        ctl_s1_d.video_on = video_on;
        ctl_s1_d.hsync    = hsync_in;
        ctl_s1_d.vsync    = vsync_in;
    end

    assign char_xy   = ctl_s1_q.in_box ? {dy_s1_q[7:4], dx_s1_q[6:3]} : BLANK_CELL_XY;
    assign font_addr = {char_code, dy_s1_q[3:0]};

    // Bit 7 of the font word is the leftmost pixel of the glyph.
    always_comb begin
        visible   = blink_phase || !blink_en || (BLINK_FRAMES == 0);
        text_on_d = ctl_s2_q.in_box && font_word[~bit_col_s2_q] && visible;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_s1_q     <= '0;
            dx_s1_q      <= '0;
            dy_s1_q      <= '0;
            ctl_s2_q     <= '0;
            bit_col_s2_q <= '0;
            text_on_q    <= 1'b0;
            text_rgb_q   <= COLOR_BLACK;
            video_on_q   <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            ctl_s1_q     <= ctl_s1_d;
            dx_s1_q      <= dx_s1_d;
            dy_s1_q      <= dy_s1_d;
            ctl_s2_q     <= ctl_s1_q;
            bit_col_s2_q <= dx_s1_q[2:0];
            text_on_q    <= text_on_d;
            text_rgb_q   <= text_on_d ? TEXT_RGB : COLOR_BLACK;
            video_on_q   <= ctl_s2_q.video_on;
            hsync_q      <= ctl_s2_q.hsync;
            vsync_q      <= ctl_s2_q.vsync;
        end
    end

    assign text_on    = text_on_q;
    assign text_rgb   = text_rgb_q;
    assign video_on_o = video_on_q;
    assign hsync_o    = hsync_q;
    assign vsync_o    = vsync_q;

endmodule

// File: tb/tb_text_banner_pixel_gen.sv
// Directed bench for text_banner_pixel_gen with behavioural char/font ROMs
// and a 3-deep expected-output history for the aligned pipeline outputs.
module tb_text_banner_pixel_gen;
    import pong_text_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, hsync_in, vsync_in, frame_tick, blink_en;
    logic [7:0]  char_xy;
    logic [6:0]  char_code;
    logic [10:0] font_addr;
    logic [7:0]  font_word;
    logic        text_on;
    logic [11:0] text_rgb;
    logic        video_on_o, hsync_o, vsync_o;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic on;
        logic hs;
        logic vs;
        logic vid;
    } exp_t;

    exp_t hist[3];
    int   b_cnt;
    logic b_phase;

    always #5 clk = ~clk;

    text_banner_pixel_gen #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .frame_tick (frame_tick),
        .blink_en   (blink_en),
        .char_xy    (char_xy),
        .char_code  (char_code),
        .font_addr  (font_addr),
        .font_word  (font_word),
        .text_on    (text_on),
        .text_rgb   (text_rgb),
        .video_on_o (video_on_o),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o)
    );

    // Glyph content depends only on the glyph row, so it is stable across tests.
    function automatic logic [7:0] font_fn(input logic [3:0] row);
        case (row)
            4'd0:    return 8'h80;
            4'd4:    return 8'hFF;
            4'd8:    return 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    always_comb char_code = CHAR_BLANK | {3'b000, char_xy[3:0]};

    always @(posedge clk) font_word <= font_fn(font_addr[3:0]);

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic apply(input logic [9:0] px, input logic [9:0] py,
                         input logic vid, input logic hs, input logic vs, input logic ft);
        logic [9:0] dxv, dyv;
        logic       inb;
        logic [7:0] xy, pat;
        logic [6:0] code;
        logic [2:0] bitsel;
        logic       on;
        pixel_x = px; pixel_y = py; video_on = vid;
        hsync_in = hs; vsync_in = vs; frame_tick = ft;
        dxv    = px - 10'd256;
        dyv    = py - 10'd16;
        inb    = (px >= 10'd256) && (px < 10'd384) && (py >= 10'd16) && (py < 10'd32) && vid;
        xy     = inb ? {dyv[7:4], dxv[6:3]} : 8'h04;
        code   = 7'h20 | {3'b000, xy[3:0]};
        pat    = font_fn(dyv[3:0]);
        bitsel = 3'd7 - dxv[2:0];
        on     = inb && pat[bitsel] && (b_phase || !blink_en);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{on: on, hs: hs, vs: vs, vid: vid};
        @(posedge clk);
        #1;
        if (!blink_en) begin
            b_cnt = 0; b_phase = 1'b1;
        end else if (ft) begin
            if (b_cnt == 1) begin
                b_cnt = 0; b_phase = ~b_phase;
            end else begin
                b_cnt++;
            end
        end
        check_val("char_xy", 16'(char_xy), 16'(xy));
        check_val("font_addr", 16'(font_addr), 16'({code, dyv[3:0]}));
        check_val("text_on", 16'(text_on), 16'(hist[2].on));
        check_val("text_rgb", 16'(text_rgb), hist[2].on ? 16'h00F : 16'h000);
        check_val("video_on_o", 16'(video_on_o), 16'(hist[2].vid));
        check_val("hsync_o", 16'(hsync_o), 16'(hist[2].hs));
        check_val("vsync_o", 16'(vsync_o), 16'(hist[2].vs));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        idle(3);
        apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic burst();
        for (int x = 256; x < 272; x++) apply(10'(x), 10'd20, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
    endtask

    initial begin
        reset = 1'b1; blink_en = 1'b0; frame_tick = 1'b0;
        pixel_x = 10'd256; pixel_y = 10'd20; video_on = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;

        // Reset held with live in-banner input: outputs stay cleared.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_text_on", 16'(text_on), 16'h0);
            check_val("rst_hsync_o", 16'(hsync_o), 16'h0);
        end
        for (int i = 0; i < 3; i++) hist[i] = '{on: 1'b0, hs: 1'b0, vs: 1'b0, vid: 1'b0};
        b_cnt = 0; b_phase = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) apply(10'd256, 10'd20, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Full banner sweep on glyph row 0 (font 8'h80).
        for (int x = 256; x < 384; x++) apply(10'(x), 10'd16, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Edges of the banner and below-origin wrap.
        apply(10'd255, 10'd20, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(10'd384, 10'd20, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(10'd383, 10'd20, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(10'd300, 10'd32, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(10'd300, 10'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(10'd10,  10'd3,  1'b1, 1'b0, 1'b0, 1'b0);
        apply(10'd300, 10'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Glyph row 8 (8'hA5) exercises every bit position.
        for (int x = 320; x < 336; x++) apply(10'(x), 10'd24, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Solid glyph row with a one-cycle video_on hole.
        for (int x = 264; x < 280; x++)
            apply(10'(x), 10'd20, (x != 270), 1'b0, 1'b0, 1'b0);
        idle(3);

        // Blinking over six frames, then blinking disabled mid-phase-0.
        blink_en = 1'b1;
        idle(1);
        burst();
        for (int t = 0; t < 6; t++) begin
            tick();
            burst();
        end
        blink_en = 1'b0;
        idle(1);
        burst();
        tick();
        burst();

        // Sync delay pattern.
        apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Reset asserted mid-line flushes the pipeline.
        for (int x = 256; x < 262; x++) apply(10'(x), 10'd20, 1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_text_on", 16'(text_on), 16'h0);
        check_val("midrst_video_on_o", 16'(video_on_o), 16'h0);
        for (int i = 0; i < 3; i++) hist[i] = '{on: 1'b0, hs: 1'b0, vs: 1'b0, vid: 1'b0};
        reset = 1'b0;
        for (int x = 256; x < 264; x++) apply(10'(x), 10'd20, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
